// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline stall/flush controller.
package hazard_pkg;

  // Controller state: normal flow, or frozen behind a multi-cycle mul/div in EX.
  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;

  // Writes to r0 are discarded, so a load to r0 can never create a load-use hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the mul/div freeze counter. Never narrower than one bit so the
  // single-cycle configuration still elaborates a legal vector.
  function automatic int cnt_w(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_muldiv_stall_counter.sv
// Down counter that times the MD_BUSY phase of a multi-cycle mul/div.
// Loads MULDIV_CYCLES-2 (the number of MD_BUSY cycles), decrements while
// enabled and never wraps below zero. 'last' flags that the next decrement
// reaches zero, i.e. the current MD_BUSY cycle is the final one.
module muldiv_stall_counter
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int CW = cnt_w(MULDIV_CYCLES);
  localparam int LOAD_INT = (MULDIV_CYCLES > 2) ? (MULDIV_CYCLES - 2) : 0;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_INT);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register; reset clears it so an aborted freeze leaves no residue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q <= ONE);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, mul/div
// freezes and taken-branch flushes. Outputs are Mealy (state + inputs).
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating
// stall_cycles / flush_events performance counters; otherwise both read 0.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int PERF_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_mem_read,
  input  logic [4:0]        id_ex_write_reg,
  input  logic              id_ex_muldiv,
  input  logic [4:0]        if_id_instr_rs,
  input  logic [4:0]        if_id_instr_rt,
  input  logic              if_id_uses_rt,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic              if_id_flush,
  output logic              muldiv_busy,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_events
);

  // A single-cycle mul/div behaves like any ALU op; a two-cycle one freezes
  // only its first EX cycle and never needs the MD_BUSY state.
  localparam bit MD_STALL = (MULDIV_CYCLES > 1);
  localparam bit MD_FSM   = (MULDIV_CYCLES > 2);

  hz_state_t state_q;
  hz_state_t state_d;
  logic      load_use;
  logic      cnt_load;
  logic      cnt_dec;
  logic      cnt_last;

  assign load_use = id_ex_mem_read && (id_ex_write_reg != REG_ZERO) &&
                    ((id_ex_write_reg == if_id_instr_rs) ||
                     (if_id_uses_rt && (id_ex_write_reg == if_id_instr_rt)));

  muldiv_stall_counter #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .last  (cnt_last)
  );

  // Next state, counter control and pipeline control outputs.
  always_comb begin
    state_d       = state_q;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if_id_flush   = 1'b0;
    muldiv_busy   = 1'b0;

    if (!rst_n) begin
      // Hold the front end and keep NOPs flowing while in reset.
      state_d       = RUN;
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            // Redirect wins; wrong-path instructions in IF/ID and ID/EX die.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (id_ex_muldiv && MD_STALL) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            if (MD_FSM) begin
              cnt_load = 1'b1;
              state_d  = MD_BUSY;
            end
          end else if (load_use) begin
            // One bubble is enough: the load moves to MEM and forwarding takes over.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MD_BUSY: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          muldiv_busy   = 1'b1;
          cnt_dec       = 1'b1;
          if (cnt_last) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] stall_d;
  logic [PERF_W-1:0] flush_q;
  logic [PERF_W-1:0] flush_d;

  // Saturating event counts: frozen-PC cycles outside reset, and flush cycles.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (rst_n && !pc_write && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
    if (if_id_flush && (flush_q != '1)) begin
      flush_d = flush_q + 1'b1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (MULDIV_CYCLES=4 and =1).
module tb_hazard_stall_unit;

  logic        clk;
  logic        rst_n;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_write_reg;
  logic        id_ex_muldiv;
  logic [4:0]  if_id_instr_rs;
  logic [4:0]  if_id_instr_rt;
  logic        if_id_uses_rt;
  logic        branch_taken;

  logic        pc_write, if_id_write, id_ex_write, id_ex_bubble;
  logic        ex_mem_bubble, if_id_flush, muldiv_busy;
  logic [31:0] stall_cycles, flush_events;

  logic        pc_write1, if_id_write1, id_ex_write1, id_ex_bubble1;
  logic        ex_mem_bubble1, if_id_flush1, muldiv_busy1;
  logic [31:0] stall_cycles1, flush_events1;

  int checks = 0;
  int errors = 0;

  // Output vector order: pc_write, if_id_write, id_ex_write, id_ex_bubble,
  // ex_mem_bubble, if_id_flush, muldiv_busy
  localparam logic [6:0] O_DEF = 7'b1110000;
  localparam logic [6:0] O_RST = 7'b0001100;
  localparam logic [6:0] O_LU  = 7'b0011000;
  localparam logic [6:0] O_MD  = 7'b0000100;
  localparam logic [6:0] O_MDB = 7'b0000101;
  localparam logic [6:0] O_BR  = 7'b1111010;

  logic [6:0] o4, o1;
  assign o4 = {pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush, muldiv_busy};
  assign o1 = {pc_write1, if_id_write1, id_ex_write1, id_ex_bubble1, ex_mem_bubble1, if_id_flush1, muldiv_busy1};

  hazard_stall_unit #(.MULDIV_CYCLES(4), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_write_reg(id_ex_write_reg),
    .id_ex_muldiv(id_ex_muldiv), .if_id_instr_rs(if_id_instr_rs),
    .if_id_instr_rt(if_id_instr_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .if_id_flush(if_id_flush), .muldiv_busy(muldiv_busy),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  hazard_stall_unit #(.MULDIV_CYCLES(1), .PERF_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_write_reg(id_ex_write_reg),
    .id_ex_muldiv(id_ex_muldiv), .if_id_instr_rs(if_id_instr_rs),
    .if_id_instr_rt(if_id_instr_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken),
    .pc_write(pc_write1), .if_id_write(if_id_write1), .id_ex_write(id_ex_write1),
    .id_ex_bubble(id_ex_bubble1), .ex_mem_bubble(ex_mem_bubble1),
    .if_id_flush(if_id_flush1), .muldiv_busy(muldiv_busy1),
    .stall_cycles(stall_cycles1), .flush_events(flush_events1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helper: applies one cycle's worth of pipeline inputs.
  task automatic set_in(input logic mr, input logic [4:0] wr, input logic md,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic br);
    id_ex_mem_read  = mr;
    id_ex_write_reg = wr;
    id_ex_muldiv    = md;
    if_id_instr_rs  = rs;
    if_id_instr_rt  = rt;
    if_id_uses_rt   = urt;
    branch_taken    = br;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(1'b1, 5'd5, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (o4 !== O_RST) begin errors++; $display("FAIL reset_outputs got %b want %b", o4, O_RST); end
    checks++;
    if (o1 !== O_RST) begin errors++; $display("FAIL reset_outputs_mc1 got %b want %b", o1, O_RST); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o4 !== O_DEF) begin errors++; $display("FAIL after_reset_defaults got %b want %b", o4, O_DEF); end
    $display("reset: outputs %b after release %b", O_RST, o4);
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_in(1'b1, 5'd5, 1'b0, 5'd5, 5'd2, 1'b0, 1'b0);
    #1;
    checks++;
    if (o4 !== O_LU) begin errors++; $display("FAIL load_use_rs got %b want %b", o4, O_LU); end
    @(negedge clk);
    set_in(1'b0, 5'd0, 1'b0, 5'd5, 5'd2, 1'b0, 1'b0);
    #1;
    checks++;
    if (o4 !== O_DEF) begin errors++; $display("FAIL load_use_next got %b want %b", o4, O_DEF); end
    @(negedge clk);
    set_in(1'b1, 5'd9, 1'b0, 5'd3, 5'd9, 1'b1, 1'b0);
    #1;
    checks++;
    if (o4 !== O_LU) begin errors++; $display("FAIL load_use_rt got %b want %b", o4, O_LU); end
    $display("load_use: rt case outputs %b", o4);
  endtask

  task automatic test_no_stall();
    @(negedge clk);
    set_in(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    #1;
    checks++;
    if (o4 !== O_DEF) begin errors++; $display("FAIL load_r0 got %b want %b", o4, O_DEF); end
    @(negedge clk);
    set_in(1'b1, 5'd7, 1'b0, 5'd3, 5'd7, 1'b0, 1'b0);
    #1;
    checks++;
    if (o4 !== O_DEF) begin errors++; $display("FAIL rt_unused got %b want %b", o4, O_DEF); end
    @(negedge clk);
    set_in(1'b0, 5'd7, 1'b0, 5'd7, 5'd7, 1'b1, 1'b0);
    #1;
    checks++;
    if (o4 !== O_DEF) begin errors++; $display("FAIL not_a_load got %b want %b", o4, O_DEF); end
    $display("no_stall: outputs %b", o4);
  endtask

  task automatic test_muldiv();
    @(negedge clk);
    set_in(1'b0, 5'd4, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0);
    #1;
    checks++;
    if (o4 !== O_MD) begin errors++; $display("FAIL muldiv_first got %b want %b", o4, O_MD); end
    checks++;
    if (o1 !== O_DEF) begin errors++; $display("FAIL muldiv_mc1 got %b want %b", o1, O_DEF); end
    // Branch and load-use during MD_BUSY must be ignored.
    @(negedge clk);
    set_in(1'b1, 5'd1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1);
    #1;
    checks++;
    if (o4 !== O_MDB) begin errors++; $display("FAIL muldiv_busy1 got %b want %b", o4, O_MDB); end
    checks++;
    if (o1 !== O_BR) begin errors++; $display("FAIL mc1_branch_after got %b want %b", o1, O_BR); end
    @(negedge clk);
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o4 !== O_MDB) begin errors++; $display("FAIL muldiv_busy2 got %b want %b", o4, O_MDB); end
    @(negedge clk);
    #1;
    checks++;
    if (o4 !== O_DEF) begin errors++; $display("FAIL muldiv_exit got %b want %b", o4, O_DEF); end
    $display("muldiv: exit outputs %b", o4);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_in(1'b0, 5'd4, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o4 !== O_MD) begin errors++; $display("FAIL b2b_first got %b want %b", o4, O_MD); end
    @(negedge clk);
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    set_in(1'b0, 5'd6, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o4 !== O_MD) begin errors++; $display("FAIL b2b_second got %b want %b", o4, O_MD); end
    @(negedge clk);
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o4 !== O_MDB) begin errors++; $display("FAIL b2b_busy got %b want %b", o4, O_MDB); end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (o4 !== O_DEF) begin errors++; $display("FAIL b2b_exit got %b want %b", o4, O_DEF); end
    $display("back_to_back: exit outputs %b", o4);
  endtask

  task automatic test_branch_load_use();
    @(negedge clk);
    set_in(1'b1, 5'd5, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (o4 !== O_BR) begin errors++; $display("FAIL branch_over_lu got %b want %b", o4, O_BR); end
    @(negedge clk);
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o4 !== O_DEF) begin errors++; $display("FAIL branch_next got %b want %b", o4, O_DEF); end
    $display("branch_load_use: outputs %b", o4);
  endtask

  task automatic test_reset_mid_muldiv();
    @(negedge clk);
    set_in(1'b0, 5'd4, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o4 !== O_MDB) begin errors++; $display("FAIL rst_mid_busy1 got %b want %b", o4, O_MDB); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (o4 !== O_RST) begin errors++; $display("FAIL rst_mid_low got %b want %b", o4, O_RST); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (o4 !== O_DEF) begin errors++; $display("FAIL rst_mid_release got %b want %b", o4, O_DEF); end
    @(negedge clk);
    #1;
    checks++;
    if (o4 !== O_DEF) begin errors++; $display("FAIL rst_mid_settled got %b want %b", o4, O_DEF); end
    $display("reset_mid_muldiv: after release %b", o4);
  endtask

  task automatic test_perf();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_in(1'b1, 5'd5, 1'b0, 5'd5, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 5'd4, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    set_in(1'b1, 5'd5, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd4) begin errors++; $display("FAIL perf_stall got %0d want 4", stall_cycles); end
    checks++;
    if (flush_events !== 32'd1) begin errors++; $display("FAIL perf_flush got %0d want 1", flush_events); end
`else
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL perf_stall_off got %0d want 0", stall_cycles); end
    checks++;
    if (flush_events !== 32'd0) begin errors++; $display("FAIL perf_flush_off got %0d want 0", flush_events); end
`endif
    $display("perf: stall_cycles %0d flush_events %0d", stall_cycles, flush_events);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_no_stall();
    test_muldiv();
    test_back_to_back();
    test_branch_load_use();
    test_reset_mid_muldiv();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
